// File: rtl/wait_state_mem_pkg.sv
// Shared encodings for the wait-state memory: per-port FSM states,
// data-port function codes and small decode helpers.
package wait_state_mem_pkg;

    // Per-port request FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } req_state_t;

    // Data-port function codes.
    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LW  = 3'd2;
    localparam logic [2:0] MEM_LBU = 3'd3;
    localparam logic [2:0] MEM_LHU = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;

    // True for the three store codes.
    function automatic logic fn_is_store(input logic [2:0] fn);
        return (fn == MEM_SB) || (fn == MEM_SH) || (fn == MEM_SW);
    endfunction

    // Natural-alignment check; byte accesses (and unknown codes) never misalign.
    function automatic logic fn_misaligned(input logic [2:0] fn, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (fn)
            MEM_LW, MEM_SW:          bad = (lo != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: bad = lo[0];
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wait_state_mem_req_fsm.sv
// Request/acknowledge sequencer for one memory port: IDLE -> WAIT -> RESP.
// The port is busy for WAIT+3 cycles per access; the commit strobe marks
// the edge that enters RESP, where data is captured and stores land.
module mem_req_fsm
    import wait_state_mem_pkg::*;
#(
    parameter int unsigned WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output req_state_t state,
    output logic       commit
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT);

    req_state_t state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: WAIT lasts WAIT+1 cycles, so the ack appears in the cycle
    // after edge N+WAIT+1 for a request sampled at edge N. Commit is
    // suppressed while reset is high so an aborted store never lands.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_WAIT;
                    cnt_next   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                    commit     = ~reset;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/wait_state_mem.sv
// Unified byte-addressed memory with separate fetch and data ports, each
// with a req/ack handshake and programmable wait states.
// Handshake: the requester raises req and holds it with address/function/
// data stable; the memory answers with a one-cycle ack, during which
// inst/rdata and err are valid. req is only sampled while the port is IDLE.
module wait_state_mem
    import wait_state_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned I_WAIT    = 0,
    parameter int unsigned D_WAIT    = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_inst,
    output logic        i_err,
    input  logic        d_req,
    input  logic [2:0]  d_fn,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        d_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [7:0] mem [0:DEPTH-1];

    req_state_t i_state;
    req_state_t d_state;
    logic       i_commit;
    logic       d_commit;

    mem_req_fsm #(.WAIT(I_WAIT)) u_i_fsm (
        .clk    (clk),
        .reset  (reset),
        .req    (i_req),
        .state  (i_state),
        .commit (i_commit)
    );

    mem_req_fsm #(.WAIT(D_WAIT)) u_d_fsm (
        .clk    (clk),
        .reset  (reset),
        .req    (d_req),
        .state  (d_state),
        .commit (d_commit)
    );

    assign i_ack  = (i_state == ST_RESP);
    assign d_ack  = (d_state == ST_RESP);
    assign d_busy = (d_state != ST_IDLE);

    // Decoded byte offsets; wrap within the array is harmless because any
    // access that would wrap is flagged out of range or misaligned.
    logic [ADDR_W-1:0] ia0, ia1, ia2, ia3;
    logic [ADDR_W-1:0] da0, da1, da2, da3;
    assign ia0 = i_addr[ADDR_W-1:0];
    assign ia1 = ia0 + ADDR_W'(1);
    assign ia2 = ia0 + ADDR_W'(2);
    assign ia3 = ia0 + ADDR_W'(3);
    assign da0 = d_addr[ADDR_W-1:0];
    assign da1 = da0 + ADDR_W'(1);
    assign da2 = da0 + ADDR_W'(2);
    assign da3 = da0 + ADDR_W'(3);

    logic i_bad;
    logic d_bad;
    assign i_bad = (i_addr[1:0] != 2'b00) || ((i_addr >> ADDR_W) != 32'd0);
    assign d_bad = fn_misaligned(d_fn, d_addr[1:0]) || ((d_addr >> ADDR_W) != 32'd0);

    logic [7:0]  db0, db1, db2, db3;
    logic [31:0] i_word;
    assign db0    = mem[da0];
    assign db1    = mem[da1];
    assign db2    = mem[da2];
    assign db3    = mem[da3];
    assign i_word = {mem[ia3], mem[ia2], mem[ia1], mem[ia0]};

    // Load extension; unknown codes behave as LB, stores return zero.
    logic [31:0] load_val;
    always_comb begin
        load_val = {{24{db0[7]}}, db0};
        case (d_fn)
            MEM_LH:  load_val = {{16{db1[7]}}, db1, db0};
            MEM_LHU: load_val = {16'd0, db1, db0};
            MEM_LW:  load_val = {db3, db2, db1, db0};
            MEM_LBU: load_val = {24'd0, db0};
            MEM_SB, MEM_SH, MEM_SW: load_val = 32'd0;
            default: load_val = {{24{db0[7]}}, db0};
        endcase
    end

    // Fetch response: captured on the edge entering RESP, cleared otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_inst <= 32'd0;
            i_err  <= 1'b0;
        end else if (i_commit) begin
            i_inst <= i_bad ? 32'd0 : i_word;
            i_err  <= i_bad;
        end else begin
            i_inst <= 32'd0;
            i_err  <= 1'b0;
        end
    end

    // Data response: captured on the edge entering RESP (pre-write contents).
    always_ff @(posedge clk) begin
        if (reset) begin
            d_rdata <= 32'd0;
            d_err   <= 1'b0;
        end else if (d_commit) begin
            d_rdata <= d_bad ? 32'd0 : load_val;
            d_err   <= d_bad;
        end else begin
            d_rdata <= 32'd0;
            d_err   <= 1'b0;
        end
    end

    // Byte-lane store commit; the array is never reset.
    always_ff @(posedge clk) begin
        if (d_commit && !d_bad) begin
            case (d_fn)
                MEM_SB: mem[da0] <= d_wdata[7:0];
                MEM_SH: begin
                    mem[da0] <= d_wdata[7:0];
                    mem[da1] <= d_wdata[15:8];
                end
                MEM_SW: begin
                    mem[da0] <= d_wdata[7:0];
                    mem[da1] <= d_wdata[15:8];
                    mem[da2] <= d_wdata[23:16];
                    mem[da3] <= d_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wait_state_mem.sv
// Self-checking bench for wait_state_mem: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a byte-map model.
module tb_wait_state_mem;
    import wait_state_mem_pkg::*;

    localparam int ADDR_W = 16;
    localparam int I_WAIT = 0;
    localparam int D_WAIT = 3;
    localparam int TMO    = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_ack;
    logic [31:0] i_inst;
    logic        i_err;
    logic        d_req = 1'b0;
    logic [2:0]  d_fn = 3'd0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        d_busy;

    int checks = 0;
    int errors = 0;

    wait_state_mem #(
        .ADDR_W(ADDR_W), .I_WAIT(I_WAIT), .D_WAIT(D_WAIT), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_inst(i_inst), .i_err(i_err),
        .d_req(d_req), .d_fn(d_fn), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .d_busy(d_busy)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [logic [31:0]];

    function automatic int fn_size(input logic [2:0] fn);
        if (fn == MEM_LW || fn == MEM_SW) return 4;
        if (fn == MEM_LH || fn == MEM_LHU || fn == MEM_SH) return 2;
        return 1;
    endfunction

    function automatic bit ref_err(input logic [2:0] fn, input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return ((a % fn_size(fn)) != 0) || (a >= (longint'(1) << ADDR_W));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] fn, input logic [31:0] addr);
        longint v;
        int     n;
        if (ref_err(fn, addr) || fn == MEM_SB || fn == MEM_SH || fn == MEM_SW) return 32'd0;
        n = fn_size(fn);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
        if ((fn == MEM_LB || fn == MEM_LH) && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] wd);
        if (!ref_err(fn, addr) && (fn == MEM_SB || fn == MEM_SH || fn == MEM_SW))
            for (int i = 0; i < fn_size(fn); i++) ref_mem[addr + i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_fetch(input logic [31:0] addr);
        if (ref_err(MEM_LW, addr)) return 32'd0;
        return ref_load(MEM_LW, addr);
    endfunction

    // ---------------- drivers (called and returning at a negedge) ----------------
    task automatic data_op(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat);
        bit got;
        got = 0;
        d_fn = fn; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        lat = 0; rd = 32'd0; er = 1'b0;
        for (int k = 0; k < TMO && !got; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (d_ack) begin
                got = 1;
                rd = d_rdata;
                er = d_err;
            end
        end
        d_req = 1'b0;
        if (!got) lat = -1;
        @(negedge clk);
        check("d_ack_single_pulse", {31'd0, d_ack}, 32'd0);
        check("d_rdata_idle_zero", d_rdata, 32'd0);
    endtask

    task automatic fetch_op(input logic [31:0] addr, output logic [31:0] inst,
                            output logic er, output int lat);
        bit got;
        got = 0;
        i_addr = addr; i_req = 1'b1;
        lat = 0; inst = 32'd0; er = 1'b0;
        for (int k = 0; k < TMO && !got; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (i_ack) begin
                got = 1;
                inst = i_inst;
                er = i_err;
            end
        end
        i_req = 1'b0;
        if (!got) lat = -1;
        @(negedge clk);
        check("i_ack_single_pulse", {31'd0, i_ack}, 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic [2:0]  fn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic reset_abort(input int k);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acks;
        data_op(MEM_SW, 32'h300, 32'hCAFE_D00D, rd, er, lat);
        check("abort_prestore_err", {31'd0, er}, 32'd0);
        d_fn = MEM_SW; d_addr = 32'h300; d_wdata = 32'h0BAD_F00D; d_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_in_wait", {31'd0, d_busy}, 32'd1);
        for (int c = 0; c < k; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        d_req = 1'b0;
        acks = 0;
        @(posedge clk);
        @(negedge clk);
        if (d_ack) acks++;
        check("abort_busy_cleared", {31'd0, d_busy}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < D_WAIT + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_ack) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        data_op(MEM_LW, 32'h300, 32'd0, rd, er, lat);
        check("abort_old_value", rd, 32'hCAFE_D00D);
    endtask

    initial begin
        logic [31:0] rd, rd2, inst;
        logic        er, er2;
        int          lat, lat2;
        int          ack_at[$];

        vecs.push_back('{"sw_100",     MEM_SW,  32'h100,   32'h1122_3344, 32'h0,          1'b0});
        vecs.push_back('{"lw_100",     MEM_LW,  32'h100,   32'h0,         32'h1122_3344,  1'b0});
        vecs.push_back('{"sb_203",     MEM_SB,  32'h203,   32'hFFFF_FF80, 32'h0,          1'b0});
        vecs.push_back('{"sb_202",     MEM_SB,  32'h202,   32'h0000_007F, 32'h0,          1'b0});
        vecs.push_back('{"lb_203",     MEM_LB,  32'h203,   32'h0,         32'hFFFF_FF80,  1'b0});
        vecs.push_back('{"lbu_203",    MEM_LBU, 32'h203,   32'h0,         32'h0000_0080,  1'b0});
        vecs.push_back('{"lh_202",     MEM_LH,  32'h202,   32'h0,         32'hFFFF_807F,  1'b0});
        vecs.push_back('{"lhu_202",    MEM_LHU, 32'h202,   32'h0,         32'h0000_807F,  1'b0});
        vecs.push_back('{"lw_102_mis", MEM_LW,  32'h102,   32'h0,         32'h0,          1'b1});
        vecs.push_back('{"sh_101_mis", MEM_SH,  32'h101,   32'hBEEF,      32'h0,          1'b1});
        vecs.push_back('{"lw_100_keep",MEM_LW,  32'h100,   32'h0,         32'h1122_3344,  1'b0});
        vecs.push_back('{"lw_oor",     MEM_LW,  32'h1_0000,32'h0,         32'h0,          1'b1});
        vecs.push_back('{"sb_oor",     MEM_SB,  32'h1_0000,32'h55,        32'h0,          1'b1});
        vecs.push_back('{"lb_0000_keep",MEM_LB, 32'h0,     32'h0,         32'h0,          1'b0});
        vecs.push_back('{"sw_fffc",    MEM_SW,  32'hFFFC,  32'h8765_4321, 32'h0,          1'b0});
        vecs.push_back('{"lw_fffc",    MEM_LW,  32'hFFFC,  32'h0,         32'h8765_4321,  1'b0});
        vecs.push_back('{"lhu_203_mis",MEM_LHU, 32'h203,   32'h0,         32'h0,          1'b1});
        vecs.push_back('{"sh_100",     MEM_SH,  32'h100,   32'hAAAA_9966, 32'h0,          1'b0});
        vecs.push_back('{"lw_100_sh",  MEM_LW,  32'h100,   32'h0,         32'h1122_9966,  1'b0});

        // Reset and reset-state outputs.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_i_ack",   {31'd0, i_ack},  32'd0);
        check("rst_d_ack",   {31'd0, d_ack},  32'd0);
        check("rst_i_err",   {31'd0, i_err},  32'd0);
        check("rst_d_err",   {31'd0, d_err},  32'd0);
        check("rst_d_busy",  {31'd0, d_busy}, 32'd0);
        check("rst_i_inst",  i_inst,  32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);

        // Clear word 0 so the byte read in the table is defined.
        data_op(MEM_SW, 32'h0, 32'h0, rd, er, lat);

        // Directed table.
        foreach (vecs[v]) begin
            data_op(vecs[v].fn, vecs[v].addr, vecs[v].wdata, rd, er, lat);
            check({vecs[v].name, "_rdata"}, rd, vecs[v].exp_rdata);
            check({vecs[v].name, "_err"}, {31'd0, er}, {31'd0, vecs[v].exp_err});
            check({vecs[v].name, "_latency"}, 32'(lat), 32'(D_WAIT + 2));
        end

        // Concurrent fetch and store to the same word.
        data_op(MEM_SW, 32'h0, 32'hAAAA_5555, rd, er, lat);
        fork
            fetch_op(32'h0, inst, er, lat);
            data_op(MEM_SW, 32'h0, 32'h1234_5678, rd2, er2, lat2);
        join
        check("conc_fetch_old", inst, 32'hAAAA_5555);
        check("conc_fetch_lat", 32'(lat), 32'(I_WAIT + 2));
        check("conc_store_lat", 32'(lat2), 32'(D_WAIT + 2));
        check("conc_store_err", {31'd0, er2}, 32'd0);
        fetch_op(32'h0, inst, er, lat);
        check("refetch_new", inst, 32'h1234_5678);
        fetch_op(32'h2, inst, er, lat);
        check("fetch_mis_err", {31'd0, er}, 32'd1);
        check("fetch_mis_inst", inst, 32'd0);
        fetch_op(32'h1_0000, inst, er, lat);
        check("fetch_oor_err", {31'd0, er}, 32'd1);

        // Reset while in WAIT, and reset on the commit edge.
        reset_abort(0);
        reset_abort(D_WAIT);

        // Request held across acks: accepted only from IDLE.
        d_fn = MEM_LW; d_addr = 32'h100; d_req = 1'b1;
        for (int c = 1; c <= TMO * 3 && ack_at.size() < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_ack) begin
                ack_at.push_back(c);
                check("held_rdata", d_rdata, 32'h1122_9966);
            end
        end
        d_req = 1'b0;
        @(negedge clk);
        check("held_ack_count", 32'(ack_at.size()), 32'd3);
        if (ack_at.size() == 3) begin
            check("held_first", 32'(ack_at[0]), 32'(D_WAIT + 2));
            check("held_gap1", 32'(ack_at[1] - ack_at[0]), 32'(D_WAIT + 3));
            check("held_gap2", 32'(ack_at[2] - ack_at[1]), 32'(D_WAIT + 3));
        end

        // Randomized traffic against the byte-map model in 0x400..0x43F.
        for (int w = 0; w < 16; w++) begin
            logic [31:0] wd;
            wd = $urandom;
            data_op(MEM_SW, 32'h400 + 32'(4 * w), wd, rd, er, lat);
            ref_store(MEM_SW, 32'h400 + 32'(4 * w), wd);
            check("rnd_fill_err", {31'd0, er}, 32'd0);
        end
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a, wd, exp_rd;
            logic [2:0]  fn;
            bit          exp_er;
            if ($urandom_range(0, 4) == 0) begin
                a = 32'h400 + 32'(4 * $urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
                exp_rd = ref_fetch(a);
                exp_er = ref_err(MEM_LW, a);
                fetch_op(a, inst, er, lat);
                check("rnd_fetch_inst", inst, exp_rd);
                check("rnd_fetch_err", {31'd0, er}, {31'd0, exp_er});
                check("rnd_fetch_lat", 32'(lat), 32'(I_WAIT + 2));
            end else begin
                fn = 3'($urandom_range(0, 7));
                a  = 32'h400 + 32'($urandom_range(0, 60));
                if ($urandom_range(0, 9) == 0) a = a | (32'h1_0000 << $urandom_range(0, 15));
                wd = $urandom;
                exp_rd = ref_load(fn, a);
                exp_er = ref_err(fn, a);
                data_op(fn, a, wd, rd, er, lat);
                ref_store(fn, a, wd);
                check("rnd_data_rdata", rd, exp_rd);
                check("rnd_data_err", {31'd0, er}, {31'd0, exp_er});
                check("rnd_data_lat", 32'(lat), 32'(D_WAIT + 2));
            end
        end
        // Sweep every word of the region once more to expose stray writes.
        for (int w = 0; w < 16; w++) begin
            data_op(MEM_LW, 32'h400 + 32'(4 * w), 32'd0, rd, er, lat);
            check("rnd_sweep", rd, ref_load(MEM_LW, 32'h400 + 32'(4 * w)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
